// File: rtl/id_ex_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_reg_pkg
// Description : Pipeline-wide constants and types. The ALU, the hazard unit
//               and the ID/EX register all depend on these definitions.
// Revision    : 1.0 - initial release
// ============================================================================
package id_ex_reg_pkg;

    // Width of the "cycles until result exists" field carried down the pipe
    localparam int TNEW_W = 2;

    // Instruction word placed in a stage that holds no real instruction
    localparam logic [31:0] NOP_INSTR_WORD = 32'h0000_0000;

    // ALU opcode encodings shared with the ALU and the decoder
    typedef enum logic [2:0] {
        ALU_SUB = 3'd0,
        ALU_ADD = 3'd1,
        ALU_OR  = 3'd2,
        ALU_LUI = 3'd3
    } alu_op_e;

    typedef logic [TNEW_W-1:0] tnew_t;

    // A result one stage further down is one cycle closer; it never goes below 0
    function automatic tnew_t tnew_advance(input tnew_t t);
        return (t == '0) ? '0 : t - tnew_t'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/id_ex_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_reg_if
// Description : Bundle of D-stage inputs, M/W forwarding sources, the hazard
//               stall and the E-stage outputs around the ID/EX register.
// Revision    : 1.0 - initial release
// ============================================================================
interface id_ex_reg_if;
    import id_ex_reg_pkg::*;

    logic        stall;

    logic [31:0] D_pc;
    logic [31:0] D_instr;
    logic [31:0] D_rsData;
    logic [31:0] D_rtData;
    logic [31:0] D_imm32;
    logic [2:0]  D_aluOp;
    logic        D_aluSrc;
    logic [4:0]  D_rsAddr;
    logic [4:0]  D_rtAddr;
    logic [4:0]  D_wAddr;
    tnew_t       D_tNew;

    logic [4:0]  M_wAddr;
    logic [31:0] M_wData;
    tnew_t       M_tNew;

    logic [4:0]  W_wAddr;
    logic [31:0] W_wData;

    logic [31:0] E_pc;
    logic [31:0] E_instr;
    logic [31:0] E_imm32;
    logic [2:0]  E_aluOp;
    logic [4:0]  E_rsAddr;
    logic [4:0]  E_rtAddr;
    logic [4:0]  E_wAddr;
    tnew_t       E_tNew;
    logic        E_valid;
    logic [31:0] E_Src1;
    logic [31:0] E_Src2;
    logic [31:0] E_rtFwd;

    // Pipeline side that feeds the register and consumes its outputs
    modport master (
        output stall,
        output D_pc, D_instr, D_rsData, D_rtData, D_imm32, D_aluOp, D_aluSrc,
        output D_rsAddr, D_rtAddr, D_wAddr, D_tNew,
        output M_wAddr, M_wData, M_tNew, W_wAddr, W_wData,
        input  E_pc, E_instr, E_imm32, E_aluOp, E_rsAddr, E_rtAddr, E_wAddr,
        input  E_tNew, E_valid, E_Src1, E_Src2, E_rtFwd
    );

    // The ID/EX register itself
    modport slave (
        input  stall,
        input  D_pc, D_instr, D_rsData, D_rtData, D_imm32, D_aluOp, D_aluSrc,
        input  D_rsAddr, D_rtAddr, D_wAddr, D_tNew,
        input  M_wAddr, M_wData, M_tNew, W_wAddr, W_wData,
        output E_pc, E_instr, E_imm32, E_aluOp, E_rsAddr, E_rtAddr, E_wAddr,
        output E_tNew, E_valid, E_Src1, E_Src2, E_rtFwd
    );

endinterface
`default_nettype wire

// File: rtl/id_ex_reg_fwd_mux.sv
`default_nettype none
// ============================================================================
// Module      : fwd_mux
// Description : Selects the freshest value of one source register from the
//               M stage, the W stage or the value latched at decode.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_mux
    import id_ex_reg_pkg::*;
(
    input  logic [4:0]  addr,
    input  logic [31:0] reg_data,
    input  logic [4:0]  m_waddr,
    input  logic [31:0] m_wdata,
    input  tnew_t       m_tnew,
    input  logic [4:0]  w_waddr,
    input  logic [31:0] w_wdata,
    output logic [31:0] fwd_data
);

    // M wins over W because it is younger; register 0 is hard-wired and never
    // forwarded; M only forwards once its result actually exists (tNew == 0)
    always_comb begin
        fwd_data = reg_data;
        if (addr != 5'd0) begin
            if ((addr == m_waddr) && (m_tnew == '0)) begin
                fwd_data = m_wdata;
            end else if (addr == w_waddr) begin
                fwd_data = w_wdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/id_ex_reg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_reg
// Description : ID/EX pipeline register with bubble insertion on stall or
//               reset, and combinational M/W forwarding onto the E operands.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_reg
    import id_ex_reg_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_WORD
)
(
    input  logic         clk,
    input  logic         reset,
    id_ex_reg_if.slave   bus
);

    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_rs_data;
    logic [31:0] r_rt_data;
    logic [31:0] r_imm32;
    alu_op_e     r_alu_op;
    logic        r_alu_src;
    logic [4:0]  r_rs_addr;
    logic [4:0]  r_rt_addr;
    logic [4:0]  r_w_addr;
    tnew_t       r_tnew;
    logic        r_valid;

    logic [31:0] w_rs_fwd;
    logic [31:0] w_rt_fwd;

    // Capture D every cycle; a reset or stall loads a non-writing bubble instead
    always_ff @(posedge clk) begin
        if (reset || bus.stall) begin
            r_pc      <= '0;
            r_instr   <= NOP_INSTR;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_imm32   <= '0;
            r_alu_op  <= ALU_SUB;
            r_alu_src <= 1'b0;
            r_rs_addr <= '0;
            r_rt_addr <= '0;
            r_w_addr  <= '0;
            r_tnew    <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_pc      <= bus.D_pc;
            r_instr   <= bus.D_instr;
            r_rs_data <= bus.D_rsData;
            r_rt_data <= bus.D_rtData;
            r_imm32   <= bus.D_imm32;
            r_alu_op  <= alu_op_e'(bus.D_aluOp);
            r_alu_src <= bus.D_aluSrc;
            r_rs_addr <= bus.D_rsAddr;
            r_rt_addr <= bus.D_rtAddr;
            r_w_addr  <= bus.D_wAddr;
            r_tnew    <= tnew_advance(bus.D_tNew);
            r_valid   <= 1'b1;
        end
    end

    fwd_mux u_fwd_rs (
        .addr     (r_rs_addr),
        .reg_data (r_rs_data),
        .m_waddr  (bus.M_wAddr),
        .m_wdata  (bus.M_wData),
        .m_tnew   (bus.M_tNew),
        .w_waddr  (bus.W_wAddr),
        .w_wdata  (bus.W_wData),
        .fwd_data (w_rs_fwd)
    );

    fwd_mux u_fwd_rt (
        .addr     (r_rt_addr),
        .reg_data (r_rt_data),
        .m_waddr  (bus.M_wAddr),
        .m_wdata  (bus.M_wData),
        .m_tnew   (bus.M_tNew),
        .w_waddr  (bus.W_wAddr),
        .w_wdata  (bus.W_wData),
        .fwd_data (w_rt_fwd)
    );

    assign bus.E_pc     = r_pc;
    assign bus.E_instr  = r_instr;
    assign bus.E_imm32  = r_imm32;
    assign bus.E_aluOp  = r_alu_op;
    assign bus.E_rsAddr = r_rs_addr;
    assign bus.E_rtAddr = r_rt_addr;
    assign bus.E_wAddr  = r_w_addr;
    assign bus.E_tNew   = r_tnew;
    assign bus.E_valid  = r_valid;
    assign bus.E_Src1   = w_rs_fwd;
    assign bus.E_rtFwd  = w_rt_fwd;
    assign bus.E_Src2   = r_alu_src ? r_imm32 : w_rt_fwd;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_reg
// Description : Self-checking bench for id_ex_reg with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_reg;

    logic clk;
    logic reset;
    int   passed;
    int   total;

    id_ex_reg_if ifc ();

    id_ex_reg dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference E-stage contents
    logic        m_valid;
    logic [31:0] m_pc, m_instr, m_rs, m_rt, m_imm;
    logic [2:0]  m_aluop;
    logic        m_alusrc;
    logic [4:0]  m_rsa, m_rta, m_wa;
    logic [1:0]  m_tnew;

    // Value a consumer in E should see for register `a` whose decode-time value was `d`
    function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] d);
        if (a == 0) return d;
        if (a == ifc.M_wAddr && ifc.M_tNew == 0) return ifc.M_wData;
        if (a == ifc.W_wAddr) return ifc.W_wData;
        return d;
    endfunction

    function automatic logic [212:0] exp_state();
        logic [31:0] s2;
        s2 = m_alusrc ? m_imm : fwd(m_rta, m_rt);
        return {m_valid, m_pc, m_instr, m_imm, m_aluop, m_rsa, m_rta, m_wa, m_tnew,
                fwd(m_rsa, m_rs), s2, fwd(m_rta, m_rt)};
    endfunction

    function automatic logic [212:0] dut_state();
        return {ifc.E_valid, ifc.E_pc, ifc.E_instr, ifc.E_imm32, ifc.E_aluOp,
                ifc.E_rsAddr, ifc.E_rtAddr, ifc.E_wAddr, ifc.E_tNew,
                ifc.E_Src1, ifc.E_Src2, ifc.E_rtFwd};
    endfunction

    // One clock edge: model the register behaviour from the inputs at the edge
    task automatic tick();
        @(posedge clk);
        if (reset || ifc.stall) begin
            m_valid = 0; m_pc = 0; m_instr = 32'h0; m_rs = 0; m_rt = 0; m_imm = 0;
            m_aluop = 0; m_alusrc = 0; m_rsa = 0; m_rta = 0; m_wa = 0; m_tnew = 0;
        end else begin
            m_valid = 1; m_pc = ifc.D_pc; m_instr = ifc.D_instr; m_rs = ifc.D_rsData;
            m_rt = ifc.D_rtData; m_imm = ifc.D_imm32; m_aluop = ifc.D_aluOp;
            m_alusrc = ifc.D_aluSrc; m_rsa = ifc.D_rsAddr; m_rta = ifc.D_rtAddr;
            m_wa = ifc.D_wAddr;
            m_tnew = (ifc.D_tNew > 0) ? ifc.D_tNew - 2'd1 : 2'd0;
        end
        #1;
    endtask

    task automatic rand_d();
        ifc.D_pc     = $urandom;
        ifc.D_instr  = $urandom;
        ifc.D_rsData = $urandom;
        ifc.D_rtData = $urandom;
        ifc.D_imm32  = $urandom;
        ifc.D_aluOp  = 3'($urandom_range(0, 7));
        ifc.D_aluSrc = 1'($urandom_range(0, 1));
        ifc.D_rsAddr = 5'($urandom_range(0, 3));
        ifc.D_rtAddr = 5'($urandom_range(0, 3));
        ifc.D_wAddr  = 5'($urandom_range(0, 31));
        ifc.D_tNew   = 2'($urandom_range(0, 3));
    endtask

    task automatic rand_mw();
        ifc.M_wAddr = 5'($urandom_range(0, 3));
        ifc.M_wData = $urandom;
        ifc.M_tNew  = 2'($urandom_range(0, 2));
        ifc.W_wAddr = 5'($urandom_range(0, 3));
        ifc.W_wData = $urandom;
    endtask

    task automatic no_mw();
        ifc.M_wAddr = 5'd31; ifc.M_wData = 32'hDEAD_0001; ifc.M_tNew = 2'd0;
        ifc.W_wAddr = 5'd30; ifc.W_wData = 32'hDEAD_0002;
    endtask

    task automatic test_reset();
        rand_d();
        ifc.D_instr = 32'hFFFF_FFFF; ifc.D_wAddr = 5'd7; ifc.D_tNew = 2'd2;
        ifc.D_rsAddr = 5'd1; ifc.D_rsData = 32'h5555_5555;
        no_mw();
        reset = 1; ifc.stall = 0;
        tick(); tick();
        total++;
        if ({ifc.E_instr, ifc.E_wAddr, ifc.E_tNew, ifc.E_valid, ifc.E_Src1} !== {32'h0, 5'd0, 2'd0, 1'b0, 32'h0})
            $display("FAIL reset_state: got instr=%h wa=%0d tnew=%0d valid=%b src1=%h, want all zero",
                     ifc.E_instr, ifc.E_wAddr, ifc.E_tNew, ifc.E_valid, ifc.E_Src1);
        else passed++;
        reset = 0;
    endtask

    task automatic test_capture();
        rand_d(); no_mw();
        ifc.D_rsAddr = 5'd5; ifc.D_rsData = 32'h11; ifc.D_tNew = 2'd2;
        ifc.stall = 0;
        tick();
        total++;
        if ({ifc.E_tNew, ifc.E_Src1, ifc.E_valid} !== {2'd1, 32'h11, 1'b1})
            $display("FAIL capture: got tnew=%0d src1=%h valid=%b, want 1 00000011 1",
                     ifc.E_tNew, ifc.E_Src1, ifc.E_valid);
        else passed++;
        total++;
        if (dut_state() !== exp_state())
            $display("FAIL capture_full: got %h want %h", dut_state(), exp_state());
        else passed++;
        // tNew saturates at zero
        ifc.D_tNew = 2'd0;
        tick();
        total++;
        if (ifc.E_tNew !== 2'd0)
            $display("FAIL tnew_sat: got %0d want 0", ifc.E_tNew);
        else passed++;
    endtask

    task automatic test_fwd_priority();
        no_mw();
        ifc.D_rsAddr = 5'd5; ifc.D_rsData = 32'h1;
        tick();
        ifc.M_wAddr = 5'd5; ifc.M_tNew = 2'd0; ifc.M_wData = 32'hAA;
        ifc.W_wAddr = 5'd5; ifc.W_wData = 32'hBB;
        #1;
        total++;
        if (ifc.E_Src1 !== 32'hAA) $display("FAIL fwd_m_first: got %h want 000000aa", ifc.E_Src1);
        else passed++;
        ifc.M_tNew = 2'd1;
        #1;
        total++;
        if (ifc.E_Src1 !== 32'hBB) $display("FAIL fwd_w_when_m_not_ready: got %h want 000000bb", ifc.E_Src1);
        else passed++;
    endtask

    task automatic test_zero_reg();
        no_mw();
        ifc.D_rtAddr = 5'd0; ifc.D_rtData = 32'h0; ifc.D_aluSrc = 0;
        tick();
        ifc.W_wAddr = 5'd0; ifc.W_wData = 32'hFF;
        ifc.M_wAddr = 5'd0; ifc.M_wData = 32'hEE; ifc.M_tNew = 2'd0;
        #1;
        total++;
        if ({ifc.E_Src2, ifc.E_rtFwd} !== 64'h0)
            $display("FAIL zero_reg: got src2=%h rtfwd=%h want 0 0", ifc.E_Src2, ifc.E_rtFwd);
        else passed++;
        ifc.D_aluSrc = 1; ifc.D_imm32 = 32'h1234;
        tick();
        total++;
        if (ifc.E_Src2 !== 32'h1234) $display("FAIL imm_src2: got %h want 00001234", ifc.E_Src2);
        else passed++;
    endtask

    task automatic test_stall();
        rand_d(); no_mw();
        ifc.D_wAddr = 5'd9; ifc.D_tNew = 2'd3;
        ifc.stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({ifc.E_valid, ifc.E_wAddr, ifc.E_tNew, ifc.E_instr} !== {1'b0, 5'd0, 2'd0, 32'h0})
                $display("FAIL stall_bubble%0d: got valid=%b wa=%0d tnew=%0d instr=%h want 0 0 0 0",
                         i, ifc.E_valid, ifc.E_wAddr, ifc.E_tNew, ifc.E_instr);
            else passed++;
            rand_d();
        end
        ifc.stall = 0;
        ifc.D_instr = 32'hCAFE_F00D;
        tick();
        total++;
        if ({ifc.E_valid, ifc.E_instr} !== {1'b1, 32'hCAFE_F00D})
            $display("FAIL stall_release: got valid=%b instr=%h want 1 cafef00d", ifc.E_valid, ifc.E_instr);
        else passed++;
    endtask

    task automatic test_reset_priority();
        rand_d();
        ifc.D_wAddr = 5'd4;
        reset = 1; ifc.stall = 0;
        tick();
        total++;
        if ({ifc.E_valid, ifc.E_wAddr} !== {1'b0, 5'd0})
            $display("FAIL reset_over_valid: got valid=%b wa=%0d want 0 0", ifc.E_valid, ifc.E_wAddr);
        else passed++;
        ifc.stall = 1;
        tick();
        total++;
        if (ifc.E_valid !== 1'b0) $display("FAIL reset_with_stall: got valid=%b want 0", ifc.E_valid);
        else passed++;
        reset = 0; ifc.stall = 0;
        rand_d();
        tick();
        total++;
        if (dut_state() !== exp_state())
            $display("FAIL reset_release: got %h want %h", dut_state(), exp_state());
        else passed++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            rand_d(); rand_mw();
            reset     = ($urandom_range(0, 15) == 0);
            ifc.stall = ($urandom_range(0, 4) == 0);
            tick();
            total++;
            if (dut_state() !== exp_state())
                $display("FAIL random_edge%0d: got %h want %h", i, dut_state(), exp_state());
            else passed++;
            rand_mw();
            #1;
            total++;
            if (dut_state() !== exp_state())
                $display("FAIL random_fwd%0d: got %h want %h", i, dut_state(), exp_state());
            else passed++;
        end
        reset = 0; ifc.stall = 0;
    endtask

    initial begin
        passed = 0; total = 0;
        reset = 1; ifc.stall = 0;
        rand_d(); no_mw();
        m_valid = 0; m_pc = 0; m_instr = 0; m_rs = 0; m_rt = 0; m_imm = 0;
        m_aluop = 0; m_alusrc = 0; m_rsa = 0; m_rta = 0; m_wa = 0; m_tnew = 0;
        @(negedge clk);
        test_reset();
        test_capture();
        test_fwd_priority();
        test_zero_reg();
        test_stall();
        test_reset_priority();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
